// File: rtl/spi_mem_sched.sv
// spi_mem_sched: sequences an SPI master to serve fetch/data requests from a 23LC512-style SRAM
// Ports: clock/reset (async active-high); if_* fetch port (read-only);
// d_* data port (read/write); spi_* command/strobe to and result from the SPI master;
// init_done high once the SRAM mode register has been written.
module spi_mem_sched #(
  parameter int ADDR_W = 16,
  parameter logic [7:0] READ_OP = 8'h03,
  parameter logic [7:0] WRITE_OP = 8'h02,
  parameter logic [7:0] WRMR_OP = 8'h01,
  parameter logic [7:0] INIT_MODE = 8'h00
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [7:0] if_rdata,
  output logic if_ack,
  input  logic d_req,
  input  logic d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic [7:0] d_rdata,
  output logic d_ack,
  output logic [31:0] spi_write_data,
  output logic [2:0] spi_write_len,
  output logic spi_read_len,
  output logic spi_send,
  input  logic [7:0] spi_read_data,
  input  logic spi_done,
  output logic init_done
);
  typedef enum logic [2:0] {INIT, INIT_WAIT, DRAIN, IDLE, ISSUE, BUSY, ACK} state_t;
  state_t state, state_n;
  logic port_d, we_q, last_d, pick_d, grant, sel_we, xfer_n, init_n, send_n;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [7:0] wd_q, sel_wd;
  logic [31:0] data_n;
  logic [2:0] wlen_n;
  always_comb begin
    state_n = state;
    case (state)
      INIT:      state_n = INIT_WAIT;
      INIT_WAIT: state_n = spi_done ? DRAIN : INIT_WAIT;
      DRAIN:     state_n = spi_done ? DRAIN : IDLE;
      IDLE:      state_n = (init_done && (if_req || d_req)) ? ISSUE : IDLE;
      ISSUE:     state_n = BUSY;
      BUSY:      state_n = spi_done ? ACK : BUSY;
      ACK:       state_n = DRAIN;
      default:   state_n = INIT;
    endcase
    // when both request, the port that was not served last wins
    pick_d = d_req && (!if_req || !last_d);
    grant = (state == IDLE) && (state_n == ISSUE);
    // in Idle the command is built from the incoming request, afterwards from the latched copy
    sel_addr = (state == IDLE) ? (pick_d ? d_addr : if_addr) : addr_q;
    sel_we = (state == IDLE) ? (pick_d && d_we) : we_q;
    sel_wd = (state == IDLE) ? d_wdata : wd_q;
    xfer_n = (state_n == ISSUE) || (state_n == BUSY);
    init_n = state_n == INIT_WAIT;
    send_n = (state == INIT) || grant;
    data_n = xfer_n ? (sel_we ? {WRITE_OP, sel_addr, sel_wd} : {READ_OP, sel_addr, 8'h00}) :
             init_n ? {WRMR_OP, INIT_MODE, 16'h0000} : 32'h0;
    wlen_n = xfer_n ? (sel_we ? 3'd4 : 3'd3) : init_n ? 3'd2 : 3'd0;
  end
  // outputs are registered from the next-state decision so reset forces them all low
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      port_d <= 1'b0;
      we_q <= 1'b0;
      last_d <= 1'b1;
      addr_q <= '0;
      wd_q <= 8'h00;
      if_rdata <= 8'h00;
      d_rdata <= 8'h00;
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      spi_write_data <= 32'h0;
      spi_write_len <= 3'd0;
      spi_read_len <= 1'b0;
      spi_send <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_n;
      spi_write_data <= data_n;
      spi_write_len <= wlen_n;
      spi_read_len <= xfer_n && !sel_we;
      spi_send <= send_n;
      if_ack <= (state_n == ACK) && !port_d;
      d_ack <= (state_n == ACK) && port_d;
      if (state == INIT_WAIT && spi_done) init_done <= 1'b1;
      if (grant) begin
        port_d <= pick_d;
        last_d <= pick_d;
        addr_q <= sel_addr;
        we_q <= sel_we;
        wd_q <= d_wdata;
      end
      if (state == BUSY && spi_done && !we_q) begin
        if (port_d) d_rdata <= spi_read_data;
        else if_rdata <= spi_read_data;
      end
    end
  end
endmodule

// File: tb/tb_spi_mem_sched.sv
// tb_spi_mem_sched: directed scoreboard bench for spi_mem_sched with a behavioural SPI master
module tb_spi_mem_sched;
  logic clock = 0, reset = 1;
  logic if_req = 0, d_req = 0, d_we = 0, if_ack, d_ack, spi_read_len, spi_send, spi_done = 0, init_done;
  logic [15:0] if_addr = 0, d_addr = 0;
  logic [7:0] d_wdata = 0, if_rdata, d_rdata, spi_read_data = 0, rd_val = 0;
  logic [31:0] spi_write_data;
  logic [2:0] spi_write_len;
  int passed = 0, total = 0, viol = 0;
  logic [35:0] sent_q[$], exp_send_q[$];
  logic [8:0] ack_q[$], exp_ack_q[$];
  logic busy = 0;
  int cnt = 0, hold = 0;

  spi_mem_sched dut (.clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .spi_write_data(spi_write_data), .spi_write_len(spi_write_len), .spi_read_len(spi_read_len),
    .spi_send(spi_send), .spi_read_data(spi_read_data), .spi_done(spi_done), .init_done(init_done));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      busy <= 0; cnt <= 0; hold <= 0; spi_done <= 0;
    end else if (spi_send && !busy && !spi_done) begin
      busy <= 1; cnt <= 3;
    end else if (busy) begin
      if (cnt == 0) begin busy <= 0; spi_done <= 1; spi_read_data <= rd_val; hold <= 2; end
      else cnt <= cnt - 1;
    end else if (spi_done) begin
      if (hold == 0) spi_done <= 0; else hold <= hold - 1;
    end
  end

  always @(negedge clock) begin
    if (spi_send) begin
      sent_q.push_back({spi_write_data, spi_write_len, spi_read_len});
      if (spi_done || busy) viol++;
    end
    if (if_ack) ack_q.push_back({1'b0, if_rdata});
    if (d_ack) ack_q.push_back({1'b1, d_rdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic exp_send(input logic [31:0] d, input logic [2:0] l, input logic r);
    exp_send_q.push_back({d, l, r});
  endtask

  task automatic get_send(input string tag);
    int n = 0;
    logic [35:0] got = '1;
    while (sent_q.size() == 0 && n < 200) begin step(1); n++; end
    if (sent_q.size() != 0) got = sent_q.pop_front();
    chk(tag, 64'(got), 64'(exp_send_q.pop_front()));
  endtask

  task automatic get_ack(input string tag);
    int n = 0;
    logic [8:0] got = '1;
    while (ack_q.size() == 0 && n < 200) begin step(1); n++; end
    if (ack_q.size() != 0) got = ack_q.pop_front();
    chk(tag, 64'(got), 64'(exp_ack_q.pop_front()));
  endtask

  initial begin
    #2;
    chk("rst_send", 64'(spi_send), 0);
    chk("rst_data", 64'({spi_write_data, spi_write_len, spi_read_len}), 0);
    chk("rst_outs", 64'({if_ack, d_ack, init_done, if_rdata, d_rdata}), 0);
    step(1);
    reset = 0;
    if_addr = 16'h0000; if_req = 1; rd_val = 8'h11;
    exp_send(32'h0100_0000, 3'd2, 1'b0);
    exp_send(32'h0300_0000, 3'd3, 1'b1);
    exp_ack_q.push_back({1'b0, 8'h11});
    get_send("init_cmd");
    chk("init_pending", 64'(init_done), 0);
    get_send("fetch0_cmd");
    chk("init_done", 64'(init_done), 1);
    get_ack("fetch0_ack");
    if_req = 0;

    if_addr = 16'hFFFF; rd_val = 8'h3C; if_req = 1;
    exp_send(32'h03FF_FF00, 3'd3, 1'b1);
    exp_ack_q.push_back({1'b0, 8'h3C});
    get_send("fetchFFFF_cmd");
    get_ack("fetchFFFF_ack");
    if_req = 0;

    d_addr = 16'h1234; d_wdata = 8'hA5; d_we = 1; d_req = 1;
    exp_send(32'h0212_34A5, 3'd4, 1'b0);
    exp_ack_q.push_back({1'b1, 8'h00});
    get_send("write1234_cmd");
    get_ack("write1234_ack");
    d_req = 0;
    step(12);
    chk("write_single_ack", 64'(ack_q.size()), 0);

    if_addr = 16'h0100; d_addr = 16'h0040; d_wdata = 8'h5A; d_we = 1; rd_val = 8'h77;
    if_req = 1; d_req = 1;
    for (int i = 0; i < 2; i++) begin
      exp_send(32'h0301_0000, 3'd3, 1'b1);
      exp_ack_q.push_back({1'b0, 8'h77});
      exp_send(32'h0200_405A, 3'd4, 1'b0);
      exp_ack_q.push_back({1'b1, 8'h00});
    end
    for (int i = 0; i < 2; i++) begin
      get_send("arb_f_cmd"); get_ack("arb_f_ack");
      get_send("arb_d_cmd"); get_ack("arb_d_ack");
    end
    if_req = 0; d_req = 0;
    step(12);
    chk("arb_ack_count", 64'(ack_q.size()), 0);
    chk("arb_send_count", 64'(sent_q.size()), 0);

    d_addr = 16'h0010; d_we = 0; rd_val = 8'h99; d_req = 1;
    exp_send(32'h0300_1000, 3'd3, 1'b1);
    exp_ack_q.push_back({1'b1, 8'h99});
    get_send("hold_cmd");
    d_addr = 16'h0020;
    @(negedge clock);
    chk("hold_busy_data", 64'(spi_write_data), 64'h0300_1000);
    get_ack("hold_ack");
    d_req = 0;
    step(12);
    chk("hold_no_extra", 64'(sent_q.size()), 0);

    d_addr = 16'h0050; d_we = 0; rd_val = 8'h66; d_req = 1;
    exp_send(32'h0300_5000, 3'd3, 1'b1);
    get_send("abort_cmd");
    reset = 1;
    #1;
    chk("abort_outs", 64'({spi_send, spi_write_data, spi_write_len, spi_read_len}), 0);
    chk("abort_init_done", 64'(init_done), 0);
    chk("abort_d_ack", 64'(d_ack), 0);
    step(2);
    reset = 0;
    chk("abort_no_ack", 64'(ack_q.size()), 0);
    exp_send(32'h0100_0000, 3'd2, 1'b0);
    exp_send(32'h0300_5000, 3'd3, 1'b1);
    exp_ack_q.push_back({1'b1, 8'h66});
    get_send("reinit_cmd");
    get_send("retry_cmd");
    get_ack("retry_ack");
    d_req = 0;
    step(12);
    chk("end_acks", 64'(ack_q.size()), 0);
    chk("end_sends", 64'(sent_q.size()), 0);
    chk("send_protocol", 64'(viol), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
